// File: rtl/prog_sequencer.sv
// Run controller: loads a program's start address into the PC, enables fetch until halt/END_PC,
// and counts RUN cycles. Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module prog_sequencer #(
  parameter int PC_W        = 10,
  parameter int CNT_W       = 16,
  parameter int START_ADDR0 = 0,
  parameter int START_ADDR1 = 261,
  parameter int START_ADDR2 = 512,
  parameter int START_ADDR3 = 681,
  parameter int END_PC      = 1023,
  parameter int TIMEOUT     = 40000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start_req,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc_value,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_addr,
  output logic             pc_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_prog,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  // state | meaning
  // IDLE  | waiting for start_req
  // LOAD  | one-cycle PC load strobe for the selected program
  // RUN   | fetch enabled, counting cycles until halt / END_PC (/ watchdog)
  // DONE  | completion reported and held until the next start_req
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  if (TIMEOUT < 1 || TIMEOUT > 2**CNT_W) begin : g_bad_timeout
    $error("prog_sequencer: TIMEOUT must fit in cycle_count");
  end

  state_t           state;
  logic [1:0]       sel_q;
  logic             end_hit;
  logic             to_hit;
  logic [CNT_W-1:0] count_next;

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] s);
    case (s)
      2'd0:    start_addr = PC_W'(START_ADDR0);
      2'd1:    start_addr = PC_W'(START_ADDR1);
      2'd2:    start_addr = PC_W'(START_ADDR2);
      default: start_addr = PC_W'(START_ADDR3);
    endcase
  endfunction

  assign end_hit    = halt || (pc_value == PC_W'(END_PC));
  assign count_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);

`ifdef SEQ_TIMEOUT_EN
  logic tmo_q;
  assign to_hit  = (cycle_count == CNT_W'(TIMEOUT - 1));
  assign timeout = tmo_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= IDLE;
      sel_q        <= 2'd0;
      pc_load      <= 1'b0;
      pc_load_addr <= '0;
      pc_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_prog    <= 2'd0;
      cycle_count  <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q        <= 1'b0;
`endif
    end else begin
      pc_load <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_req) begin
            sel_q        <= prog_sel;
            pc_load      <= 1'b1;
            pc_load_addr <= start_addr(prog_sel);
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          cycle_count <= '0;
`ifdef SEQ_TIMEOUT_EN
          tmo_q       <= 1'b0;
`endif
          pc_en       <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          // The ending cycle is counted; a real end condition beats the watchdog.
          cycle_count <= count_next;
          if (end_hit || to_hit) begin
            pc_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            done_prog <= sel_q;
`ifdef SEQ_TIMEOUT_EN
            tmo_q     <= ~end_hit;
`endif
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed runs with a completion scoreboard.
// Expectations follow SEQ_TIMEOUT_EN when the bench is built with it.
module tb_prog_sequencer;
  localparam int PC_W    = 10;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 80;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic             start_req = 1'b0;
  logic [1:0]       prog_sel = 2'd0;
  logic             halt = 1'b0;
  logic [PC_W-1:0]  pc_value = 10'd100;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_addr;
  logic             pc_en;
  logic             busy;
  logic             done;
  logic [1:0]       done_prog;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  prog_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .START_ADDR0(0), .START_ADDR1(261),
    .START_ADDR2(512), .START_ADDR3(681), .END_PC(1023), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .Reset(Reset), .start_req(start_req), .prog_sel(prog_sel),
    .halt(halt), .pc_value(pc_value), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .pc_en(pc_en), .busy(busy), .done(done), .done_prog(done_prog),
    .cycle_count(cycle_count), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {int prog; int cnt; int tmo;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  logic done_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int addr_of(input int s);
    case (s)
      0: return 0;
      1: return 261;
      2: return 512;
      default: return 681;
    endcase
  endfunction

  // Issue start_req from IDLE/DONE; returns sampled in the first RUN cycle.
  task automatic launch(input int sel);
    prog_sel  = sel[1:0];
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    chk("load_strobe", pc_load, 1);
    chk("load_addr", pc_load_addr, addr_of(sel));
    chk("load_busy", busy, 1);
    chk("load_pc_en", pc_en, 0);
    chk("load_done", done, 0);
    step();
    chk("run_pc_en", pc_en, 1);
    chk("run_pc_load", pc_load, 0);
    chk("run_count0", cycle_count, 0);
    chk("run_timeout0", timeout, 0);
  endtask

  // mode 0: halt, 1: END_PC, 2: both. k = RUN edges already taken; ends on RUN cycle n.
  task automatic finish_run(input int sel, input int n, input int k, input int mode);
    sb.push_back('{prog: sel, cnt: n, tmo: 0});
    repeat (n - 1 - k) step();
    if (mode != 1) halt = 1'b1;
    if (mode != 0) pc_value = 10'd1023;
    step();
    halt = 1'b0;
    pc_value = 10'd100;
    chk("end_done", done, 1);
    chk("end_pc_en", pc_en, 0);
    chk("end_busy", busy, 0);
    chk("end_count", cycle_count, n);
    chk("end_prog", done_prog, sel);
    chk("end_timeout", timeout, 0);
  endtask

  // Completion monitor: every rising done must match the oldest expected result.
  always @(posedge CLK) begin
    #1;
    if (mon_on) begin
      chk("load_en_excl", pc_load & pc_en, 0);
      if (done && !done_d) begin
        if (sb.size() == 0) begin
          chk("sb_spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_prog", done_prog, e.prog);
          chk("sb_count", cycle_count, e.cnt);
          chk("sb_timeout", timeout, e.tmo);
        end
      end
      done_d = done;
    end
  end

  initial begin
    int i;
    repeat (3) step();
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_addr", pc_load_addr, 0);
    chk("rst_done_prog", done_prog, 0);
    chk("rst_count", cycle_count, 0);
    Reset = 1'b0;
    mon_on = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    launch(1);
    finish_run(1, 5, 0, 0);
    launch(0);
    finish_run(0, 10, 0, 0);
    repeat (3) step();
    chk("done_held", done, 1);
    chk("count_frozen", cycle_count, 10);
    chk("done_prog_held", done_prog, 0);

    launch(2);
    finish_run(2, 7, 0, 1);
    launch(3);
    finish_run(3, 4, 0, 2);
    repeat (3) step();
    chk("dual_end_count", cycle_count, 4);
    chk("dual_end_done", done, 1);

    // start_req held through LOAD and pulsed mid-RUN must be ignored
    prog_sel  = 2'd2;
    start_req = 1'b1;
    step();
    prog_sel  = 2'd3;
    chk("ign_load_addr", pc_load_addr, 512);
    step();
    start_req = 1'b0;
    chk("ign_load_pc_load", pc_load, 0);
    chk("ign_load_pc_en", pc_en, 1);
    repeat (4) step();
    prog_sel  = 2'd1;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    chk("ign_run_pc_load", pc_load, 0);
    chk("ign_run_pc_en", pc_en, 1);
    chk("ign_run_count", cycle_count, 5);
    finish_run(2, 12, 5, 0);

    // reset in the middle of a run
    launch(1);
    repeat (57) step();
    chk("mid_count", cycle_count, 57);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_rst_pc_en", pc_en, 0);
    chk("mid_rst_count", cycle_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done_prog", done_prog, 0);
    step();
    chk("mid_rst_idle", busy, 0);

`ifdef SEQ_TIMEOUT_EN
    sb.push_back('{prog: 3, cnt: TIMEOUT, tmo: 1});
    launch(3);
    for (i = 0; i < 200 && !done; i++) step();
    chk("tmo_done", done, 1);
    chk("tmo_cycles", i, TIMEOUT);
    chk("tmo_flag", timeout, 1);
    chk("tmo_count", cycle_count, TIMEOUT);
    chk("tmo_prog", done_prog, 3);
    launch(1);
    finish_run(1, TIMEOUT, 0, 0);
`else
    launch(3);
    for (i = 0; i < 300 && !done; i++) step();
    chk("notmo_done", done, 0);
    chk("notmo_busy", busy, 1);
    chk("notmo_pc_en", pc_en, 1);
    chk("notmo_timeout", timeout, 0);
    chk("sat_count", cycle_count, 255);
    sb.push_back('{prog: 3, cnt: 255, tmo: 0});
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("sat_end_done", done, 1);
    chk("sat_end_count", cycle_count, 255);
`endif

    repeat (2) step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Run controller for the program counter and fetch path. It accepts a start request with a program select, loads the selected program's start address into the PC, and enables fetch while the program runs. It detects program end (halt instruction or end-of-program PC), counts execution cycles and reports completion to the testbench/top level. It sits between the top-level run interface and the PC block; the PC keeps ownership of branch/jump arithmetic.

Parameters:
PC_W, 10, PC width
CNT_W, 16, cycle counter width
START_ADDR0, 0, start address of program 0
START_ADDR1, 261, start address of program 1
START_ADDR2, 512, start address of program 2
START_ADDR3, 681, start address of program 3
END_PC, 1023, PC value treated as implicit halt
TIMEOUT, 40000, RUN-cycle limit (used only with SEQ_TIMEOUT_EN)

Ports:
CLK  in  1  clock, all state on posedge
Reset  in  1  synchronous, active-high reset
start_req  in  1  single-cycle request to launch a program
prog_sel  in  2  program index, sampled with start_req
halt  in  1  decoder flag: halt instruction in current cycle
pc_value  in  PC_W  current PC from PC block
pc_load  out  1  one-cycle strobe: PC <= pc_load_addr
pc_load_addr  out  PC_W  start address for the load
pc_en  out  1  PC/fetch advance enable
busy  out  1  high in LOAD and RUN
done  out  1  level, high in DONE
done_prog  out  2  index of the program that completed
cycle_count  out  CNT_W  RUN cycles of the current/last program
timeout  out  1  last program ended by watchdog

Behaviour:
- Reset (sync, synchronous priority over all inputs): state IDLE; pc_load, pc_en, busy, done, timeout = 0; pc_load_addr, done_prog, cycle_count = 0. Reset mid-RUN: IDLE on the next edge, count cleared, no done pulse.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state/registers only.
- IDLE: pc_en = 0. start_req = 1 -> latch prog_sel into sel_q -> LOAD.
- LOAD (exactly 1 cycle): pc_load = 1, pc_load_addr = START_ADDR[sel_q], cycle_count <= 0, timeout <= 0, busy = 1 -> RUN.
- RUN: pc_en = 1, busy = 1, cycle_count increments by 1 per cycle and saturates at all-ones without wrapping. End condition: halt = 1 or pc_value == END_PC. On end, the ending cycle is counted -> DONE, done_prog <= sel_q. If halt and END_PC occur together, the result is a single end event with identical behaviour.
- DONE: done = 1 (held), pc_en = 0, cycle_count frozen. start_req -> latch prog_sel -> LOAD; done drops on that edge.
- start_req is ignored in LOAD and RUN; there is no queueing.
- Latency: start_req at edge t (IDLE) gives pc_load high in cycle t+1, pc_en high from t+2, and the first counted cycle at t+2.
- pc_load and pc_en are never high in the same cycle.
- done_prog holds its value until the next end event.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: in RUN, when cycle_count == TIMEOUT-1 and no end condition occurs -> DONE with timeout <= 1 and done_prog <= sel_q. A real end condition in the same cycle wins, and timeout stays 0.
- Undefined: no watchdog; timeout is tied 0 and the port is still present.

Test Plan:
- Reset, then start_req with prog_sel=1 -> pc_load=1 with pc_load_addr=261 one cycle later; pc_en=1 from the following cycle; busy=1.
- Run program 0, halt asserted on the 10th RUN cycle -> done=1, done_prog=0, cycle_count=10, pc_en=0 next cycle.
- pc_value driven to 1023 with halt=0 -> DONE; with halt=1 in the same cycle -> one DONE entry, cycle_count unchanged by the duplicate condition.
- start_req pulsed in LOAD and mid-RUN -> ignored. start_req in DONE with prog_sel=3 -> done drops, pc_load_addr=681, count restarts at 0.
- Reset asserted mid-RUN (cycle_count=57) -> next cycle state IDLE, pc_en=0, cycle_count=0, done=0.
- SEQ_TIMEOUT_EN with TIMEOUT=20 and no halt -> DONE after 20 RUN cycles, timeout=1. Rebuilt without the macro, the same stimulus -> stays in RUN and timeout=0.
